// File: rtl/ysyx_22050612_pkg.sv
// ysyx_22050612_pkg: shared widths and write-back requester indices
package ysyx_22050612_pkg;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_REQ    = 3;
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;
endpackage

// File: rtl/ysyx_22050612_rr_arbiter.sv
// ysyx_22050612_rr_arbiter: round-robin one-hot grant, pointer moves only on advance
module ysyx_22050612_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int W = $clog2(N);
    logic [W-1:0] last_grant;
    logic [W-1:0] gnt_idx;
    int i;
    // scan farthest-first so the requester right after last_grant wins last
    always_comb begin
        gnt = '0;
        gnt_idx = last_grant;
        i = 0;
        for (int k = N; k >= 1; k--) begin
            i = (int'(last_grant) + k) % N;
            if (req[W'(i)]) begin
                gnt = '0;
                gnt[W'(i)] = 1'b1;
                gnt_idx = W'(i);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= W'(N - 1);
        else if (advance) last_grant <= gnt_idx;
    end
endmodule

// File: rtl/ysyx_22050612_wb_arbiter.sv
// ysyx_22050612_wb_arbiter: shares the register-file write port and tracks pending writes
module ysyx_22050612_wb_arbiter
    import ysyx_22050612_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          iss_valid,
    input  logic [ADDR_WIDTH-1:0]         iss_addr,
    input  logic [ADDR_WIDTH-1:0]         rs1,
    input  logic [ADDR_WIDTH-1:0]         rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [NUM_REQ-1:0]    gnt;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DEPTH-1:0]      pending, set_mask, clr_mask;

    ysyx_22050612_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (hs),
        .gnt     (gnt)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // x0 writes still handshake but never reach the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= hs && (sel_addr != '0);
            if (hs) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    assign set_mask = iss_valid ? (DEPTH'(1) << iss_addr) : '0;
    assign clr_mask = rf_wen ? (DEPTH'(1) << rf_waddr) : '0;

    // a new producer issued on the commit edge supersedes the committing one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else pending <= ((pending & ~clr_mask) | set_mask) & ~DEPTH'(1);
    end

    assign rs1_busy = pending[rs1];
    assign rs2_busy = pending[rs2];
endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// tb_ysyx_22050612_wb_arbiter: scoreboard bench for the write-back arbiter
module tb_ysyx_22050612_wb_arbiter;
    import ysyx_22050612_pkg::*;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr, rs1, rs2;
    logic              rs1_busy, rs2_busy, rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;

    ysyx_22050612_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [NR-1:0] v;
    logic [AW-1:0] a[NR];
    logic [DW-1:0] d[NR];
    logic          pend[32];
    int            m_last, last_g, n_chk, n_pass;
    logic          cur_wen;
    logic [AW-1:0] cur_addr;
    int            gl[$];
    int            exp_order[6] = '{0, 1, 2, 0, 1, 2};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_last  = NR - 1;
        cur_wen = 1'b0;
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    endtask

    task automatic drive();
        req_valid = v;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
    endtask

    // entered at posedge+1; leaves at the next posedge+1
    task automatic cycle();
        exp_t e;
        int   g;
        drive();
        #1;
        g = -1;
        for (int k = 1; k <= NR; k++)
            if (g < 0 && v[(m_last + k) % NR]) g = (m_last + k) % NR;
        last_g = g;
        chk("ready", {61'b0, req_ready}, g < 0 ? 64'd0 : 64'd1 << g);
        chk("rs1_busy", {63'b0, rs1_busy}, {63'b0, pend[rs1]});
        chk("rs2_busy", {63'b0, rs2_busy}, {63'b0, pend[rs2]});
        e.wen  = g >= 0 && a[g] != 0;
        e.addr = g >= 0 ? a[g] : '0;
        e.data = g >= 0 ? d[g] : '0;
        q.push_back(e);
        @(posedge clk);
        if (cur_wen) pend[cur_addr] = 1'b0;
        if (iss_valid && iss_addr != 0) pend[iss_addr] = 1'b1;
        if (g >= 0) begin
            m_last = g;
            v[g] = 1'b0;
        end
        #1;
        e = q.pop_front();
        chk("rf_wen", {63'b0, rf_wen}, {63'b0, e.wen});
        if (e.wen) begin
            chk("rf_waddr", {59'b0, rf_waddr}, {59'b0, e.addr});
            chk("rf_wdata", rf_wdata, e.data);
        end
        cur_wen   = e.wen;
        cur_addr  = e.addr;
        iss_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        iss_valid = 1'b0;
        iss_addr = '0;
        rs1 = '0;
        rs2 = '0;
        n_chk = 0;
        n_pass = 0;
        last_g = -1;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wen", {63'b0, rf_wen}, 64'd0);
        chk("rst_waddr", {59'b0, rf_waddr}, 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_ready", {61'b0, req_ready}, 64'd0);
        chk("rst_busy", {63'b0, rs1_busy | rs2_busy}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single LSU write to x5
        v[WB_LSU] = 1'b1; a[WB_LSU] = 5'd5; d[WB_LSU] = 64'hAB;
        repeat (3) cycle();

        // CSR write to x0: handshake without a register-file write
        v[WB_CSR] = 1'b1; a[WB_CSR] = 5'd0; d[WB_CSR] = 64'h55;
        iss_valid = 1'b1; iss_addr = 5'd0; rs1 = 5'd0;
        cycle();
        chk("x0_hs", last_g, WB_CSR);
        cycle();
        chk("x0_busy", {63'b0, rs1_busy}, 64'd0);

        // all requesters valid: rotation 0,1,2,0,1,2
        gl.delete();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NR; i++) begin
                v[i] = 1'b1;
                a[i] = AW'(i + 1);
                d[i] = 64'(i * 256 + n);
            end
            cycle();
            gl.push_back(last_g);
        end
        for (int n = 0; n < 6; n++) chk($sformatf("order%0d", n), gl[n], exp_order[n]);
        v = '0;
        cycle();

        // RAW on x7: busy until the commit edge
        iss_valid = 1'b1; iss_addr = 5'd7; rs1 = 5'd7;
        cycle();
        chk("x7_busy_set", {63'b0, rs1_busy}, 64'd1);
        v[WB_LSU] = 1'b1; a[WB_LSU] = 5'd7; d[WB_LSU] = 64'h77;
        cycle();
        chk("x7_busy_wen", {63'b0, rs1_busy}, 64'd1);
        cycle();
        chk("x7_busy_clr", {63'b0, rs1_busy}, 64'd0);

        // reissue of x9 on its commit edge keeps it pending
        iss_valid = 1'b1; iss_addr = 5'd9; rs2 = 5'd9;
        cycle();
        v[WB_ALU] = 1'b1; a[WB_ALU] = 5'd9; d[WB_ALU] = 64'h99;
        cycle();
        iss_valid = 1'b1; iss_addr = 5'd9;
        cycle();
        chk("x9_set_wins", {63'b0, rs2_busy}, 64'd1);
        cycle();

        // reset while a write is registered
        iss_valid = 1'b1; iss_addr = 5'd4; rs1 = 5'd4;
        v[WB_CSR] = 1'b1; a[WB_CSR] = 5'd4; d[WB_CSR] = 64'h44;
        cycle();
        chk("pre_rst_wen", {63'b0, rf_wen}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", {63'b0, rf_wen}, 64'd0);
        chk("mid_rst_busy", {63'b0, rs1_busy | rs2_busy}, 64'd0);
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v[WB_ALU] = 1'b1; a[WB_ALU] = 5'd3; d[WB_ALU] = 64'h33;
        v[WB_LSU] = 1'b1; a[WB_LSU] = 5'd6; d[WB_LSU] = 64'h66;
        cycle();
        chk("post_rst_gnt", last_g, WB_ALU);
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
